agc_lock_ctrl: RTL and testbench
================================

# agc_lock_ctrl

Sequencer and lock supervisor for the AGC loop. Holds the AGC in reset, brings its reference up, and selects a fast or slow sample interval. It watches the AGC error stream to declare lock, detect loss of lock, and retry or flag a fault on acquisition timeout. It sits beside the AGC and drives its `rst`, `i_ref_data` and `i_sample_interval`; it consumes the AGC error signal.

## Interface
- `RST_CYCLES`, 16: cycles `o_agc_rst` is held high per (re)start.
- `LOCK_TOL`, 8: \|err\| ≤ this counts as in-tolerance.
- `UNLOCK_TOL`, 32: \|err\| > this counts as out-of-tolerance.
- `LOCK_COUNT`, 64: consecutive in-tolerance samples needed to declare lock.
- `UNLOCK_COUNT`, 16: consecutive out-of-tolerance samples needed to drop lock.
- `ACQ_TIMEOUT`, 4096: valid samples allowed in ACQ before a retry.
- `MAX_RETRY`, 3: retries allowed before FAULT.
- `RAMP_STEP`, 16: ref increment per ramp cycle (macro build only).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_enable` in 1: run request; low forces IDLE.
- `i_target_ref` in 10: target amplitude reference.
- `i_fast_interval` in 8: sample interval used outside LOCK.
- `i_slow_interval` in 8: sample interval used in LOCK.
- `i_err` in 11: signed AGC error, ref minus measured amplitude.
- `i_err_valid` in 1: `i_err` qualifier.
- `o_agc_rst` out 1: AGC reset.
- `o_ref_data` out 10: AGC reference.
- `o_sample_interval` out 8: AGC sample interval.
- `o_locked` out 1: high only in LOCK.
- `o_fault` out 1: high only in FAULT.
- `o_state` out 3: current state encoding.

## Operation
**States:** IDLE=0, RSTA=1, RAMP=2, ACQ=3, LOCK=4, FAULT=5.

**Transitions:**
- IDLE → RSTA when `i_enable` is high; the retry count is cleared.
- RSTA: `o_agc_rst`=1 and `o_ref_data`=0 for `RST_CYCLES` cycles, then → RAMP. Without the macro, RSTA → ACQ directly.
- RAMP: `o_ref_data` += `RAMP_STEP` each cycle, saturating at `i_target_ref`. When equal → ACQ.
- ACQ:
  - `o_ref_data` = `i_target_ref` (tracks live).
  - In-tolerance counter increments on each valid in-tolerance sample and clears on each valid out-of-tolerance sample. Invalid cycles hold the counter.
  - Counter reaching `LOCK_COUNT` → LOCK.
  - `ACQ_TIMEOUT` valid samples without lock: retry count +1 and → RSTA.
  - If the retry count already equals `MAX_RETRY`, → FAULT instead.
- LOCK:
  - Unlock counter counts consecutive valid samples with \|err\| > `UNLOCK_TOL`. Any valid sample at or below `UNLOCK_TOL` clears it.
  - Counter reaching `UNLOCK_COUNT` → ACQ, with all counters cleared; the retry count is unchanged.
- FAULT: `o_agc_rst`=1 and stays there until `i_enable` is low.

**Global rules:**
- `i_enable` low in any state → IDLE next cycle, clearing all counters and the retry count.
- IDLE: `o_agc_rst`=1, `o_ref_data`=0.

**Arithmetic:**
- \|err\| is computed as an 11-bit unsigned value; −1024 maps to 1024, with no wrap.
- Counters saturate and never wrap.

**Sample interval:** `o_sample_interval` = `i_slow_interval` in LOCK, otherwise `i_fast_interval`.

## Timing
- All outputs are registered.
- Reset values: `o_agc_rst`=1, `o_ref_data`=0, `o_sample_interval`=0, `o_locked`=0, `o_fault`=0, `o_state`=0.
- Latency: a valid sample that completes a count changes `o_state` and its dependent outputs on the next clock edge.
- `o_agc_rst` falls on the same edge that `o_state` leaves RSTA.
- If `i_enable` falls on the same cycle as a lock, unlock or timeout event, the fall wins and the next state is IDLE.
- `i_err_valid` is ignored in IDLE, RSTA, RAMP and FAULT.
- A `rst` assertion mid-operation returns all outputs to their reset values on the next edge.

## Configuration
- `AGC_CTRL_RAMP_EN` defined: the RAMP state exists and the reference rises in steps of `RAMP_STEP` after RSTA. If `i_target_ref` < `RAMP_STEP`, the first ramp cycle saturates to target.
- Not defined: no RAMP state and no `RAMP_STEP` logic. `o_ref_data` jumps to `i_target_ref` on entering ACQ. Encoding 2 never appears on `o_state`.

## Structure
- Package `agc_ctrl_pkg`: state enum (3-bit), error width 11, ref width 10, interval width 8.
- Sub-module `agc_tol_counter`: consecutive-event counter with saturating terminal flag and synchronous clear. Instantiated twice, once for lock and once for unlock.

## Test plan
- Enable from reset: `o_agc_rst` is high for exactly 16 cycles. With the macro and target 100, `o_ref_data` steps 16, 32, …, 96, 100, then ACQ.
- Feed err=+5 valid every cycle: `o_locked` rises on the edge after the 64th sample, and `o_sample_interval` switches from fast to slow.
- In ACQ, feed 63 in-tolerance samples, then err=20, then 63 more: no lock; the 64th consecutive in-tolerance sample locks.
- In LOCK, feed err=−1024 for 15 samples, then err=0, then 16 samples of −40: no unlock after the first 15; unlock → ACQ after the 16th −40 sample.
- Feed err=200 continuously (use small `ACQ_TIMEOUT`=8): three retries through RSTA, then FAULT, with `o_fault`=1 and `o_agc_rst`=1. Dropping `i_enable` → IDLE.
- Drop `i_enable` on the same cycle as the 64th lock sample: next state is IDLE and `o_locked` stays 0.

Source files
------------

// File: rtl/agc_ctrl_pkg.sv
// Shared widths, state encodings and error-magnitude helper for the AGC lock controller.
package agc_ctrl_pkg;

   localparam int ERR_W  = 11;
   localparam int REF_W  = 10;
   localparam int INTV_W = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RSTA  = 3'd1,
      S_RAMP  = 3'd2,
      S_ACQ   = 3'd3,
      S_LOCK  = 3'd4,
      S_FAULT = 3'd5
   } agc_state_e;

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_RSTA  = S_RSTA;
   localparam logic [2:0] ST_RAMP  = S_RAMP;
   localparam logic [2:0] ST_ACQ   = S_ACQ;
   localparam logic [2:0] ST_LOCK  = S_LOCK;
   localparam logic [2:0] ST_FAULT = S_FAULT;

   // Unsigned magnitude in the same width; the most negative code maps to 1024 without wrapping.
   function automatic logic [ERR_W-1:0] err_mag(input logic [ERR_W-1:0] err);
      logic [ERR_W-1:0] mag;
      if (err[ERR_W-1]) begin
         mag = ~err + 11'd1;
      end else begin
         mag = err;
      end
      return mag;
   endfunction

endpackage

// File: rtl/agc_tol_counter.sv
// Consecutive-event counter: saturates at TERM, synchronous clear wins over increment,
// hit_o flags the increment that reaches (or re-reaches) TERM.
module agc_tol_counter #(
   parameter int TERM = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   localparam int CW = $clog2(TERM + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CW'(TERM))) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = inc_i && (cnt_q >= CW'(TERM - 1));

endmodule

// File: rtl/agc_lock_ctrl.sv
// AGC reset/reference sequencer with lock supervision, acquisition timeout and retry/fault.
// Optional reference ramp after reset is enabled by defining AGC_CTRL_RAMP_EN.
module agc_lock_ctrl
   import agc_ctrl_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TOL     = 8,
   parameter int UNLOCK_TOL   = 32,
   parameter int LOCK_COUNT   = 64,
   parameter int UNLOCK_COUNT = 16,
   parameter int ACQ_TIMEOUT  = 4096,
`ifdef AGC_CTRL_RAMP_EN
   parameter int MAX_RETRY    = 3,
   parameter int RAMP_STEP    = 16
`else
   parameter int MAX_RETRY    = 3
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   input  logic [REF_W-1:0]  i_target_ref,
   input  logic [INTV_W-1:0] i_fast_interval,
   input  logic [INTV_W-1:0] i_slow_interval,
   input  logic [ERR_W-1:0]  i_err,
   input  logic              i_err_valid,
   output logic              o_agc_rst,
   output logic [REF_W-1:0]  o_ref_data,
   output logic [INTV_W-1:0] o_sample_interval,
   output logic              o_locked,
   output logic              o_fault,
   output logic [2:0]        o_state
);

   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam int TCW = $clog2(ACQ_TIMEOUT + 1);
   localparam int YCW = $clog2(MAX_RETRY + 1);

`ifdef AGC_CTRL_RAMP_EN
   localparam logic [2:0] ST_POST_RST = ST_RAMP;
`else
   localparam logic [2:0] ST_POST_RST = ST_ACQ;
`endif

   logic [2:0]        state_q,   state_d;
   logic [RCW-1:0]    rcnt_q,    rcnt_d;
   logic [TCW-1:0]    tcnt_q,    tcnt_d;
   logic [YCW-1:0]    retry_q,   retry_d;
   logic              agc_rst_q, agc_rst_d;
   logic [REF_W-1:0]  ref_q,     ref_d;
   logic [INTV_W-1:0] intv_q,    intv_d;
   logic              locked_q,  locked_d;
   logic              fault_q,   fault_d;

   logic [ERR_W-1:0]  err_abs_s;
   logic              in_acq_s, in_lock_s, state_chg_s;
   logic              lock_inc_s, lock_clr_s, lock_hit_s;
   logic              unl_inc_s,  unl_clr_s,  unl_hit_s;
   logic              tmo_s;

   assign err_abs_s   = err_mag(i_err);
   assign in_acq_s    = (state_q == ST_ACQ);
   assign in_lock_s   = (state_q == ST_LOCK);
   assign state_chg_s = (state_d != state_q);

   // The error stream only matters in ACQ and LOCK; counters restart on every state change.
   assign lock_inc_s = in_acq_s && i_err_valid && (err_abs_s <= ERR_W'(LOCK_TOL));
   assign lock_clr_s = !in_acq_s || state_chg_s ||
                       (i_err_valid && (err_abs_s > ERR_W'(LOCK_TOL)));
   assign unl_inc_s  = in_lock_s && i_err_valid && (err_abs_s > ERR_W'(UNLOCK_TOL));
   assign unl_clr_s  = !in_lock_s || state_chg_s ||
                       (i_err_valid && (err_abs_s <= ERR_W'(UNLOCK_TOL)));
   assign tmo_s      = in_acq_s && i_err_valid && (tcnt_q >= TCW'(ACQ_TIMEOUT - 1));

   agc_tol_counter #(.TERM(LOCK_COUNT)) u_lock_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (lock_clr_s),
      .inc_i (lock_inc_s),
      .hit_o (lock_hit_s)
   );

   agc_tol_counter #(.TERM(UNLOCK_COUNT)) u_unlock_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (unl_clr_s),
      .inc_i (unl_inc_s),
      .hit_o (unl_hit_s)
   );

`ifdef AGC_CTRL_RAMP_EN
   logic [REF_W:0]   ramp_sum_s;
   logic [REF_W-1:0] ramp_next_s;

   assign ramp_sum_s  = {1'b0, ref_q} + (REF_W + 1)'(RAMP_STEP);
   assign ramp_next_s = (ramp_sum_s >= {1'b0, i_target_ref}) ? i_target_ref
                                                             : ramp_sum_s[REF_W-1:0];
`endif

   // Next-state logic; a low enable overrides every other event.
   always_comb begin
      state_d = state_q;
      if (!i_enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_RSTA;
            ST_RSTA: begin
               if (rcnt_q >= RCW'(RST_CYCLES - 1)) begin
                  state_d = ST_POST_RST;
               end else begin
                  state_d = ST_RSTA;
               end
            end
`ifdef AGC_CTRL_RAMP_EN
            ST_RAMP: begin
               if (ref_q == i_target_ref) begin
                  state_d = ST_ACQ;
               end else begin
                  state_d = ST_RAMP;
               end
            end
`endif
            ST_ACQ: begin
               if (lock_hit_s) begin
                  state_d = ST_LOCK;
               end else if (tmo_s) begin
                  state_d = (retry_q == YCW'(MAX_RETRY)) ? ST_FAULT : ST_RSTA;
               end else begin
                  state_d = ST_ACQ;
               end
            end
            ST_LOCK: begin
               if (unl_hit_s) begin
                  state_d = ST_ACQ;
               end else begin
                  state_d = ST_LOCK;
               end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Reset-hold timer, acquisition sample counter and retry bookkeeping.
   always_comb begin
      rcnt_d  = '0;
      tcnt_d  = '0;
      retry_d = retry_q;
      if ((state_q == ST_RSTA) && (state_d == ST_RSTA) && (rcnt_q != RCW'(RST_CYCLES))) begin
         rcnt_d = rcnt_q + RCW'(1);
      end else if ((state_q == ST_RSTA) && (state_d == ST_RSTA)) begin
         rcnt_d = rcnt_q;
      end else begin
         rcnt_d = '0;
      end
      if (in_acq_s && (state_d == ST_ACQ)) begin
         if (i_err_valid && (tcnt_q != TCW'(ACQ_TIMEOUT))) begin
            tcnt_d = tcnt_q + TCW'(1);
         end else begin
            tcnt_d = tcnt_q;
         end
      end else begin
         tcnt_d = '0;
      end
      if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
         retry_d = '0;
      end else if (in_acq_s && (state_d == ST_RSTA) && (retry_q != YCW'(MAX_RETRY))) begin
         retry_d = retry_q + YCW'(1);
      end else begin
         retry_d = retry_q;
      end
   end

   // Output values are decoded from the next state so they change with o_state.
   always_comb begin
      agc_rst_d = 1'b1;
      ref_d     = '0;
      intv_d    = i_fast_interval;
      locked_d  = 1'b0;
      fault_d   = 1'b0;
      case (state_d)
         ST_IDLE, ST_RSTA: begin
            agc_rst_d = 1'b1;
            ref_d     = '0;
         end
`ifdef AGC_CTRL_RAMP_EN
         ST_RAMP: begin
            agc_rst_d = 1'b0;
            ref_d     = ramp_next_s;
         end
`endif
         ST_ACQ: begin
            agc_rst_d = 1'b0;
            ref_d     = i_target_ref;
         end
         ST_LOCK: begin
            agc_rst_d = 1'b0;
            ref_d     = i_target_ref;
            intv_d    = i_slow_interval;
            locked_d  = 1'b1;
         end
         ST_FAULT: begin
            agc_rst_d = 1'b1;
            fault_d   = 1'b1;
         end
         default: begin
            agc_rst_d = 1'b1;
            ref_d     = '0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rcnt_q    <= '0;
         tcnt_q    <= '0;
         retry_q   <= '0;
         agc_rst_q <= 1'b1;
         ref_q     <= '0;
         intv_q    <= '0;
         locked_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         tcnt_q    <= tcnt_d;
         retry_q   <= retry_d;
         agc_rst_q <= agc_rst_d;
         ref_q     <= ref_d;
         intv_q    <= intv_d;
         locked_q  <= locked_d;
         fault_q   <= fault_d;
      end
   end

   assign o_agc_rst         = agc_rst_q;
   assign o_ref_data        = ref_q;
   assign o_sample_interval = intv_q;
   assign o_locked          = locked_q;
   assign o_fault           = fault_q;
   assign o_state           = state_q;

endmodule

// File: tb/tb_agc_lock_ctrl.sv
// Randomized bench for agc_lock_ctrl: a run-length reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_agc_lock_ctrl;

   localparam int TMO = 160;
   localparam int I_ = 0, R_ = 1, P_ = 2, A_ = 3, L_ = 4, F_ = 5;
`ifdef AGC_CTRL_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        i_enable;
   logic [9:0]  i_target_ref;
   logic [7:0]  i_fast_interval;
   logic [7:0]  i_slow_interval;
   logic [10:0] i_err;
   logic        i_err_valid;
   logic        o_agc_rst;
   logic [9:0]  o_ref_data;
   logic [7:0]  o_sample_interval;
   logic        o_locked;
   logic        o_fault;
   logic [2:0]  o_state;

   agc_lock_ctrl #(.ACQ_TIMEOUT(TMO)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_enable          (i_enable),
      .i_target_ref      (i_target_ref),
      .i_fast_interval   (i_fast_interval),
      .i_slow_interval   (i_slow_interval),
      .i_err             (i_err),
      .i_err_valid       (i_err_valid),
      .o_agc_rst         (o_agc_rst),
      .o_ref_data        (o_ref_data),
      .o_sample_interval (o_sample_interval),
      .o_locked          (o_locked),
      .o_fault           (o_fault),
      .o_state           (o_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase plus run lengths of good/bad samples, updated per clock edge.
   int m_st, m_rstc, m_run, m_bad, m_smp, m_retry, m_ref;
   int e_rst, e_ref, e_si, e_lk, e_ft;
   bit m_ok = 1'b0;

   always @(posedge clk) begin : p_model
      int e, a, nst, tgt;
      e   = int'($signed(i_err));
      a   = (e < 0) ? -e : e;
      tgt = int'(i_target_ref);
      if (rst) begin
         m_st = I_; m_rstc = 0; m_run = 0; m_bad = 0; m_smp = 0; m_retry = 0; m_ref = 0;
         e_rst = 1; e_ref = 0; e_si = 0; e_lk = 0; e_ft = 0;
         m_ok = 1'b1;
      end else begin
         nst = m_st;
         if (!i_enable) nst = I_;
         else if (m_st == I_) nst = R_;
         else if (m_st == R_) begin
            if (m_rstc + 1 >= 16) nst = RAMP_EN ? P_ : A_;
         end else if (m_st == P_) begin
            if (m_ref == tgt) nst = A_;
         end else if (m_st == A_ && i_err_valid) begin
            if (a <= 8 && m_run + 1 >= 64) nst = L_;
            else if (m_smp + 1 >= TMO) nst = (m_retry == 3) ? F_ : R_;
         end else if (m_st == L_ && i_err_valid && a > 32 && m_bad + 1 >= 16) nst = A_;

         if (nst != m_st) begin
            m_run = 0; m_bad = 0; m_smp = 0;
         end else if (m_st == A_ && i_err_valid) begin
            m_smp++;
            m_run = (a <= 8) ? m_run + 1 : 0;
         end else if (m_st == L_ && i_err_valid) begin
            m_bad = (a > 32) ? m_bad + 1 : 0;
         end
         m_rstc = (nst == R_ && m_st == R_) ? m_rstc + 1 : 0;
         if (nst == I_ || m_st == I_) m_retry = 0;
         else if (m_st == A_ && nst == R_) m_retry++;

         if (nst == P_) m_ref = (m_ref + 16 >= tgt) ? tgt : m_ref + 16;
         else if (nst == A_ || nst == L_) m_ref = tgt;
         else m_ref = 0;

         m_st  = nst;
         e_ref = m_ref;
         e_rst = (nst == I_ || nst == R_ || nst == F_) ? 1 : 0;
         e_lk  = (nst == L_) ? 1 : 0;
         e_ft  = (nst == F_) ? 1 : 0;
         e_si  = (nst == L_) ? int'(i_slow_interval) : int'(i_fast_interval);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_state",    int'(o_state),           m_st);
         chk("m_agc_rst",  int'(o_agc_rst),         e_rst);
         chk("m_interval", int'(o_sample_interval), e_si);
         chk("m_locked",   int'(o_locked),          e_lk);
         chk("m_fault",    int'(o_fault),           e_ft);
         if (m_st != F_) chk("m_ref", int'(o_ref_data), e_ref);
      end
   end

   function automatic int small_err();
      return int'($urandom_range(16, 0)) - 8;
   endfunction

   task automatic drive(input int e, input bit v);
      i_err       = 11'(e);
      i_err_valid = v;
      @(negedge clk);
   endtask

   task automatic wait_state(input int s, input string nm);
      int n;
      n = 0;
      while (int'(o_state) != s && n < 2000) begin
         drive(0, 1'b0);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         failures++;
         $display("FAIL %s wait expired state=%0d expected=%0d", nm, o_state, s);
      end
   endtask

   initial begin
      int rc, ramp_n, first, last, n, entries, prev, mode, e;
      bit v;
      rst = 1'b1; i_enable = 1'b0; i_target_ref = 10'd100;
      i_fast_interval = 8'h11; i_slow_interval = 8'h80;
      i_err = 11'd0; i_err_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_agc_rst", int'(o_agc_rst), 1);
      chk("rst_state", int'(o_state), 0);
      chk("rst_ref", int'(o_ref_data), 0);
      chk("rst_interval", int'(o_sample_interval), 0);
      rst = 1'b0;
      drive(0, 1'b0);

      // Start-up: reset hold length and ramp profile.
      i_enable = 1'b1;
      rc = 0; ramp_n = 0; first = -1; last = -1;
      for (int k = 0; k < 200 && int'(o_state) != A_; k++) begin
         drive(0, 1'b0);
         if (o_state == 3'd1 && o_agc_rst) rc++;
         if (o_state == 3'd2) begin
            ramp_n++;
            last = int'(o_ref_data);
            if (ramp_n == 1) first = int'(o_ref_data);
         end
      end
      chk("rsta_len", rc, 16);
      chk("ramp_cycles", ramp_n, RAMP_EN ? 7 : 0);
      if (RAMP_EN) begin
         chk("ramp_first", first, 16);
         chk("ramp_last", last, 100);
      end
      chk("acq_ref", int'(o_ref_data), 100);
      chk("acq_agc_rst", int'(o_agc_rst), 0);

      // Lock after 64 consecutive in-tolerance samples.
      n = 0;
      while (!o_locked && n < 200) begin
         drive(small_err(), 1'b1);
         n++;
      end
      chk("lock_samples", n, 64);
      chk("slow_interval", int'(o_sample_interval), 128);

      // Unlock needs 16 consecutive large errors.
      repeat (15) drive(-1024, 1'b1);
      drive(0, 1'b1);
      repeat (15) drive(-40, 1'b1);
      chk("still_locked", int'(o_locked), 1);
      drive(-40, 1'b1);
      chk("unlock_state", int'(o_state), 3);
      chk("unlock_locked", int'(o_locked), 0);
      chk("fast_interval", int'(o_sample_interval), 17);

      // A single mid-range error restarts the in-tolerance run.
      repeat (63) drive(small_err(), 1'b1);
      drive(20, 1'b1);
      repeat (63) drive(small_err(), 1'b1);
      chk("no_early_lock", int'(o_locked), 0);
      drive(small_err(), 1'b1);
      chk("late_lock", int'(o_locked), 1);

      // Randomized segments, checked by the model.
      for (int seg = 0; seg < 50; seg++) begin
         mode = int'($urandom_range(2, 0));
         for (int c = 0; c < 100; c++) begin
            v = ($urandom_range(9, 0) < 8);
            if (mode == 0) e = small_err();
            else if (mode == 1) e = int'($urandom_range(2047, 0)) - 1024;
            else e = ($urandom_range(1, 0) == 1) ? small_err() : int'($urandom_range(80, 0)) - 40;
            i_enable = ($urandom_range(400, 0) != 0);
            if ($urandom_range(100, 0) == 0) i_target_ref = 10'($urandom_range(1023, 0));
            if ($urandom_range(200, 0) == 0) i_slow_interval = 8'($urandom_range(255, 0));
            if ($urandom_range(200, 0) == 0) i_fast_interval = 8'($urandom_range(255, 0));
            rst = (seg == 25 && c == 10);
            drive(e, v);
         end
      end
      rst = 1'b0;

      // Persistent large error: initial attempt plus three retries, then fault.
      i_target_ref = 10'd100;
      i_enable = 1'b0;
      drive(0, 1'b0);
      i_enable = 1'b1;
      entries = 0; prev = int'(o_state); n = 0;
      while (!o_fault && n < 3000) begin
         drive(200, 1'b1);
         if (o_state == 3'd1 && prev != 1) entries++;
         prev = int'(o_state);
         n++;
      end
      chk("rsta_entries", entries, 4);
      chk("fault_flag", int'(o_fault), 1);
      chk("fault_agc_rst", int'(o_agc_rst), 1);
      repeat (5) drive(200, 1'b1);
      chk("fault_hold", int'(o_state), 5);
      i_enable = 1'b0;
      drive(0, 1'b0);
      chk("fault_exit", int'(o_state), 0);
      chk("fault_clear", int'(o_fault), 0);

      // Enable falling together with the locking sample wins.
      i_enable = 1'b1;
      wait_state(A_, "reach_acq");
      repeat (63) drive(small_err(), 1'b1);
      i_enable = 1'b0;
      drive(small_err(), 1'b1);
      chk("drop_state", int'(o_state), 0);
      chk("drop_locked", int'(o_locked), 0);
      drive(0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
